bank_stream_reader: RTL

Read-side master for the dual-port SRAM `bank` block. On a start command it reads a run of consecutive bank words through the bank's read port (`vsi_outputChipSelect` / `vsi_outputAddr` / `vsi_outputData`). It returns them as a valid/ready stream with a last flag. A small credit-controlled FIFO absorbs the 1-cycle SRAM read latency and downstream backpressure, so no read data is ever dropped or duplicated.

---
 rtl/bank_pkg.sv | 15 +
 rtl/bank_rd_fifo.sv | 62 ++++++
 rtl/bank_stream_reader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bank_pkg.sv
// Shared definitions for the dual-port SRAM bank and its read/write masters.
package bank_pkg;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } rd_state_t;

endpackage

// File: rtl/bank_rd_fifo.sv
// Small synchronous FIFO holding captured bank words plus their end-of-run flag.
module bank_rd_fifo #(
  parameter int WIDTH   = 128,
  parameter int ENTRIES = 4,
  localparam int CNT_W  = $clog2(ENTRIES + 1),
  localparam int PTR_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pushLast,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             popLast,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] dataMem [ENTRIES];
  logic             lastMem [ENTRIES];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign doPop   = pop && !empty;
  assign popData = dataMem[rdPtr];
  assign popLast = lastMem[rdPtr];

  // Storage is cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        dataMem[i] <= '0;
        lastMem[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        dataMem[wrPtr] <= pushData;
        lastMem[wrPtr] <= pushLast;
        wrPtr          <= bump(wrPtr);
      end
      if (doPop) begin
        rdPtr <= bump(rdPtr);
      end
      if (push && !doPop) begin
        count <= count + CNT_W'(1);
      end else if (!push && doPop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bank_stream_reader.sv
// Reads a run of consecutive bank words and returns them as a valid/ready
// stream, using a credit-limited FIFO to cover SRAM latency and backpressure.
module bank_stream_reader #(
  parameter int DATA_W     = bank_pkg::DATA_W,
  parameter int ADDR_W     = bank_pkg::ADDR_W,
  parameter int DEPTH      = bank_pkg::DEPTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              vsi_clk,
  input  logic              vsi_reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              vsi_outputChipSelect,
  output logic [ADDR_W-1:0] vsi_outputAddr,
  input  logic [DATA_W-1:0] vsi_outputData,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  import bank_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  rd_state_t         state;
  rd_state_t         stateNext;
  logic [ADDR_W:0]   issueCnt;
  logic [ADDR_W:0]   issueCntNext;
  logic [ADDR_W:0]   beatCnt;
  logic [ADDR_W:0]   beatCntNext;
  logic [ADDR_W-1:0] addrNext;
  logic              pending;
  logic              csNext;
  logic              pop;
  logic              fifoEmpty;
  logic              headLast;
  logic [CNT_W-1:0]  fifoCount;
  logic [CNT_W:0]    countNext;
  logic [CNT_W:0]    creditUsed;

  assign out_valid = !fifoEmpty;
  assign out_last  = out_valid && headLast;
  assign pop       = out_valid && out_ready;

  // Chip-select is registered, so the issue decision is made one cycle ahead
  // using next-cycle FIFO occupancy plus the read that will then be pending.
  always_comb begin
    stateNext    = state;
    issueCntNext = issueCnt;
    beatCntNext  = pop ? beatCnt - ONE : beatCnt;
    addrNext     = vsi_outputAddr;
    unique case (state)
      IDLE: begin
        if (start) begin
          issueCntNext = length;
          beatCntNext  = length;
          addrNext     = base_addr;
          stateNext    = (length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (vsi_outputChipSelect) begin
          issueCntNext = issueCnt - ONE;
          addrNext     = (vsi_outputAddr == ADDR_W'(DEPTH - 1)) ? '0
                                                                : vsi_outputAddr + ADDR_W'(1);
          if (issueCnt == ONE) begin
            stateNext = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (beatCntNext == '0) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
    countNext  = {1'b0, fifoCount} + {{CNT_W{1'b0}}, pending} - {{CNT_W{1'b0}}, pop};
    creditUsed = countNext + {{CNT_W{1'b0}}, vsi_outputChipSelect};
    csNext     = (stateNext == RUN) && (issueCntNext != '0)
                 && (creditUsed < (CNT_W + 1)'(FIFO_DEPTH));
  end

  always_ff @(posedge vsi_clk or posedge vsi_reset) begin
    if (vsi_reset) begin
      state                <= IDLE;
      issueCnt             <= '0;
      beatCnt              <= '0;
      pending              <= 1'b0;
      vsi_outputChipSelect <= 1'b0;
      vsi_outputAddr       <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
    end else begin
      state                <= stateNext;
      issueCnt             <= issueCntNext;
      beatCnt              <= beatCntNext;
      pending              <= vsi_outputChipSelect;
      vsi_outputChipSelect <= csNext;
      vsi_outputAddr       <= addrNext;
      busy                 <= (stateNext != IDLE);
      done                 <= (stateNext == DONE);
    end
  end

  // A captured word is the final one once every read has been issued.
  bank_rd_fifo #(
    .WIDTH  (DATA_W),
    .ENTRIES(FIFO_DEPTH)
  ) rdFifo (
    .clock   (vsi_clk),
    .reset   (vsi_reset),
    .push    (pending),
    .pushData(vsi_outputData),
    .pushLast(issueCnt == '0),
    .pop     (pop),
    .popData (out_data),
    .popLast (headLast),
    .count   (fifoCount),
    .empty   (fifoEmpty)
  );

endmodule
